// File: rtl/contador_pkg.sv
// Shared defaults and helpers for the multichannel pop counter.
//   DEF_NUM_CH / DEF_CNT_W / DEF_IDX_W : default geometry of the counter bank
//   cnt_max(width)                     : largest value a width-bit counter holds
package contador_pkg;

    localparam int DEF_NUM_CH = 4;
    localparam int DEF_CNT_W  = 6;
    localparam int DEF_IDX_W  = 2;

    // Computed in 64 bits so a 32-bit counter width does not overflow the shift.
    function automatic longint unsigned cnt_max(input int unsigned width);
        return (64'd1 << width) - 64'd1;
    endfunction

endpackage

// File: rtl/contador_canal.sv
// One channel of the pop counter: registered pop strobe, saturating count of
// pops issued, and a sticky saturation flag.
//   clk, reset : clock and asynchronous active-high reset
//   enable     : global pop enable
//   empty      : this channel's FIFO empty flag
//   clear      : clear-on-read request for this channel (same edge as capture)
//   pop        : registered pop strobe to the FIFO
//   count      : current pop count (saturates at all ones)
//   sat        : set when a pop arrives while count is already at its maximum
module contador_canal
    import contador_pkg::*;
#(
    parameter int CNT_W     = DEF_CNT_W,
    parameter int BACK2BACK = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             empty,
    input  logic             clear,
    output logic             pop,
    output logic [CNT_W-1:0] count,
    output logic             sat
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max(CNT_W));

    logic pop_next;

    // Throttled mode forbids a pop in the cycle right after a pop.
    assign pop_next = enable & ~empty & ((BACK2BACK != 0) | ~pop);

    // NOTE: reset is in the sensitivity list so it acts without a clock edge,
    // and every clocked assignment is non-blocking so all flops see pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pop   <= 1'b0;
            count <= '0;
            sat   <= 1'b0;
        end else begin
            pop <= pop_next;
            if (clear) begin
                // A pop landing on the clearing edge is the first of the new epoch.
                count <= CNT_W'(pop_next);
                sat   <= 1'b0;
            end else if (pop_next) begin
                if (count == CNT_MAX) begin
                    sat <= 1'b1;
                end else begin
                    count <= count + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/contador_multicanal.sv
// Per-channel pop counter bank for the transaction-layer FIFOs.
//   clk, reset   : clock and asynchronous active-high reset
//   enable       : global pop enable (0 = no pops, counters hold)
//   empty        : FIFO empty flags, bit i = channel i
//   pop          : registered pop strobes
//   request, idx : indexed read request, sampled on clk
//   contador_out : registered count of the addressed channel (0 unless valid)
//   valid        : one-cycle strobe the cycle after request
//   idx_err      : with valid, idx addressed a channel that does not exist
//   sat          : sticky per-channel saturation flags
module contador_multicanal
    import contador_pkg::*;
#(
    parameter int NUM_CH      = DEF_NUM_CH,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int IDX_W       = DEF_IDX_W,
    parameter int BACK2BACK   = 1,
    parameter int CLR_ON_READ = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [NUM_CH-1:0] empty,
    output logic [NUM_CH-1:0] pop,
    input  logic              request,
    input  logic [IDX_W-1:0]  idx,
    output logic [CNT_W-1:0]  contador_out,
    output logic              valid,
    output logic              idx_err,
    output logic [NUM_CH-1:0] sat
);

    if ((1 << IDX_W) < NUM_CH) begin : g_idx_w_check
        $error("contador_multicanal: IDX_W=%0d cannot address NUM_CH=%0d channels", IDX_W, NUM_CH);
    end
    if (NUM_CH < 2 || NUM_CH > 16) begin : g_num_ch_check
        $error("contador_multicanal: NUM_CH=%0d outside 2..16", NUM_CH);
    end

    logic [CNT_W-1:0]  counts [NUM_CH];
    logic [NUM_CH-1:0] clear;
    logic [CNT_W-1:0]  rd_val;
    logic              idx_ok;

    assign idx_ok = (int'(idx) < NUM_CH);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign clear[i] = (CLR_ON_READ != 0) & request & (int'(idx) == i);

        contador_canal #(
            .CNT_W     (CNT_W),
            .BACK2BACK (BACK2BACK)
        ) u_canal (
            .clk    (clk),
            .reset  (reset),
            .enable (enable),
            .empty  (empty[i]),
            .clear  (clear[i]),
            .pop    (pop[i]),
            .count  (counts[i]),
            .sat    (sat[i])
        );
    end

    // Read mux; an index with no matching channel falls through to zero.
    always_comb begin
        // NOTE: default assigned first so no path leaves rd_val unassigned (no latch).
        rd_val = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (int'(idx) == i) begin
                rd_val = counts[i];
            end
        end
    end

    // Capture uses the pre-edge count, so a pop or clear on the same edge is never seen.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid        <= 1'b0;
            idx_err      <= 1'b0;
            contador_out <= '0;
        end else begin
            valid        <= request;
            idx_err      <= request & ~idx_ok;
            contador_out <= request ? rd_val : '0;
        end
    end

endmodule

// File: tb/tb_contador_multicanal.sv
module tb_contador_multicanal;

    // Three configurations under test:
    //   u_a : 4 ch, 6-bit, back-to-back, no clear-on-read
    //   u_b : 4 ch, 3-bit, throttled, clear-on-read
    //   u_c : 3 ch (IDX_W=2), 6-bit, back-to-back, no clear-on-read
    function automatic int nch(input int k);
        return (k == 2) ? 3 : 4;
    endfunction
    function automatic int cw(input int k);
        return (k == 1) ? 3 : 6;
    endfunction
    function automatic int b2b(input int k);
        return (k == 1) ? 0 : 1;
    endfunction
    function automatic int cor(input int k);
        return (k == 1) ? 1 : 0;
    endfunction

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset;

    bit       en   [3];
    logic [3:0] emp [3];
    bit       req  [3];
    int       idxv [3];

    logic       a_enable, a_request, a_valid, a_idx_err;
    logic [3:0] a_empty, a_pop, a_sat;
    logic [1:0] a_idx;
    logic [5:0] a_contador_out;

    logic       b_enable, b_request, b_valid, b_idx_err;
    logic [3:0] b_empty, b_pop, b_sat;
    logic [1:0] b_idx;
    logic [2:0] b_contador_out;

    logic       c_enable, c_request, c_valid, c_idx_err;
    logic [2:0] c_empty, c_pop, c_sat;
    logic [1:0] c_idx;
    logic [5:0] c_contador_out;

    assign a_enable  = en[0];
    assign a_empty   = emp[0];
    assign a_request = req[0];
    assign a_idx     = 2'(idxv[0]);
    assign b_enable  = en[1];
    assign b_empty   = emp[1];
    assign b_request = req[1];
    assign b_idx     = 2'(idxv[1]);
    assign c_enable  = en[2];
    assign c_empty   = emp[2][2:0];
    assign c_request = req[2];
    assign c_idx     = 2'(idxv[2]);

    contador_multicanal u_a (
        .clk(clk), .reset(reset), .enable(a_enable), .empty(a_empty), .pop(a_pop),
        .request(a_request), .idx(a_idx), .contador_out(a_contador_out),
        .valid(a_valid), .idx_err(a_idx_err), .sat(a_sat)
    );

    contador_multicanal #(
        .NUM_CH(4), .CNT_W(3), .IDX_W(2), .BACK2BACK(0), .CLR_ON_READ(1)
    ) u_b (
        .clk(clk), .reset(reset), .enable(b_enable), .empty(b_empty), .pop(b_pop),
        .request(b_request), .idx(b_idx), .contador_out(b_contador_out),
        .valid(b_valid), .idx_err(b_idx_err), .sat(b_sat)
    );

    contador_multicanal #(
        .NUM_CH(3), .CNT_W(6), .IDX_W(2), .BACK2BACK(1), .CLR_ON_READ(0)
    ) u_c (
        .clk(clk), .reset(reset), .enable(c_enable), .empty(c_empty), .pop(c_pop),
        .request(c_request), .idx(c_idx), .contador_out(c_contador_out),
        .valid(c_valid), .idx_err(c_idx_err), .sat(c_sat)
    );

    // Reference model: per channel, the number of pops issued since the last
    // clear. The visible count is that number capped at the maximum, and the
    // channel is saturated once more pops were issued than the counter holds.
    int          issued   [3][4];
    bit          last_pop [3][4];
    logic [31:0] exp_pop [3], exp_valid [3], exp_cnt [3], exp_err [3], exp_sat [3];

    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 4; i++) begin
                issued[k][i]   = 0;
                last_pop[k][i] = 1'b0;
            end
            exp_pop[k] = 0; exp_valid[k] = 0; exp_cnt[k] = 0; exp_err[k] = 0; exp_sat[k] = 0;
        end
    endtask

    // Advance the model across one rising edge using the inputs now applied.
    task automatic model_edge();
        for (int k = 0; k < 3; k++) begin
            int mx;
            mx = (1 << cw(k)) - 1;
            exp_valid[k] = 32'(req[k]);
            exp_err[k]   = 0;
            exp_cnt[k]   = 0;
            if (req[k]) begin
                if (idxv[k] >= nch(k)) exp_err[k] = 1;
                else exp_cnt[k] = (issued[k][idxv[k]] > mx) ? mx : issued[k][idxv[k]];
            end
            exp_pop[k] = 0;
            exp_sat[k] = 0;
            for (int i = 0; i < nch(k); i++) begin
                bit p;
                p = en[k] && !emp[k][i] && (b2b(k) != 0 || !last_pop[k][i]);
                if (cor(k) != 0 && req[k] && idxv[k] == i) issued[k][i] = int'(p);
                else issued[k][i] += int'(p);
                last_pop[k][i] = p;
                exp_pop[k][i]  = p;
                exp_sat[k][i]  = (issued[k][i] > mx);
            end
        end
    endtask

    task automatic cmp_inst(input int k, input logic [31:0] p, input logic [31:0] v,
                            input logic [31:0] c, input logic [31:0] e, input logic [31:0] s);
        check($sformatf("u%0d.pop", k),   p, exp_pop[k]);
        check($sformatf("u%0d.valid", k), v, exp_valid[k]);
        check($sformatf("u%0d.cnt", k),   c, exp_cnt[k]);
        check($sformatf("u%0d.err", k),   e, exp_err[k]);
        check($sformatf("u%0d.sat", k),   s, exp_sat[k]);
    endtask

    task automatic compare_all();
        cmp_inst(0, 32'(a_pop), 32'(a_valid), 32'(a_contador_out), 32'(a_idx_err), 32'(a_sat));
        cmp_inst(1, 32'(b_pop), 32'(b_valid), 32'(b_contador_out), 32'(b_idx_err), 32'(b_sat));
        cmp_inst(2, 32'(c_pop), 32'(c_valid), 32'(c_contador_out), 32'(c_idx_err), 32'(c_sat));
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic idle_all();
        for (int k = 0; k < 3; k++) begin
            en[k] = 1'b0; emp[k] = 4'hF; req[k] = 1'b0; idxv[k] = 0;
        end
    endtask

    typedef struct {
        bit         en;
        logic [3:0] empty;
        bit         req;
        int         idx;
        logic [3:0] pop;
        bit         valid;
        int         cnt;
    } vec_t;

    initial begin
        vec_t tbl [9];
        int   npops;

        // Directed vectors for u_a starting from a freshly reset bank.
        tbl[0] = '{1'b1, 4'b1110, 1'b0, 0, 4'b0001, 1'b0, 0};
        tbl[1] = '{1'b1, 4'b1110, 1'b0, 0, 4'b0001, 1'b0, 0};
        tbl[2] = '{1'b1, 4'b1110, 1'b0, 0, 4'b0001, 1'b0, 0};
        tbl[3] = '{1'b0, 4'b1110, 1'b1, 0, 4'b0000, 1'b1, 3};
        tbl[4] = '{1'b1, 4'b0000, 1'b1, 1, 4'b1111, 1'b1, 0};
        tbl[5] = '{1'b1, 4'b0000, 1'b1, 2, 4'b1111, 1'b1, 1};
        tbl[6] = '{1'b1, 4'b1111, 1'b1, 3, 4'b0000, 1'b1, 2};
        tbl[7] = '{1'b0, 4'b0000, 1'b0, 0, 4'b0000, 1'b0, 0};
        tbl[8] = '{1'b0, 4'b0000, 1'b1, 0, 4'b0000, 1'b1, 5};

        reset = 1'b1;
        idle_all();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        reset = 1'b0;

        // Traffic, then reset asserted between edges.
        for (int k = 0; k < 3; k++) begin
            en[k] = 1'b1; emp[k] = 4'h0; req[k] = 1'b1; idxv[k] = 1;
        end
        repeat (3) tick();
        #3;
        reset = 1'b1;
        model_reset();
        #1;
        compare_all();
        @(posedge clk);
        #1;
        compare_all();
        reset = 1'b0;
        idle_all();
        tick();

        for (int v = 0; v < 9; v++) begin
            en[0] = tbl[v].en; emp[0] = tbl[v].empty; req[0] = tbl[v].req; idxv[0] = tbl[v].idx;
            tick();
            check($sformatf("tbl%0d.pop", v),   32'(a_pop),          32'(tbl[v].pop));
            check($sformatf("tbl%0d.valid", v), 32'(a_valid),        32'(tbl[v].valid));
            check($sformatf("tbl%0d.cnt", v),   32'(a_contador_out), 32'(tbl[v].cnt));
            check($sformatf("tbl%0d.err", v),   32'(a_idx_err),      32'(0));
        end
        idle_all();

        // Throttle on u_b channel 1: alternate pops, then read 3.
        en[1] = 1'b1; emp[1] = 4'b1101;
        for (int c = 0; c < 6; c++) begin
            tick();
            check($sformatf("thr.pop1.%0d", c), 32'(b_pop[1]), 32'((c % 2) == 0));
        end
        en[1] = 1'b0; req[1] = 1'b1; idxv[1] = 1;
        tick();
        check("thr.valid", 32'(b_valid), 32'(1));
        check("thr.cnt", 32'(b_contador_out), 32'(3));
        req[1] = 1'b0;

        // Saturation on u_b channel 2: ten pops into a 3-bit counter.
        en[1] = 1'b1; emp[1] = 4'b1011; npops = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            npops += int'(b_pop[2]);
        end
        check("sat.npops", 32'(npops), 32'(10));
        check("sat.flag", 32'(b_sat[2]), 32'(1));
        en[1] = 1'b0; req[1] = 1'b1; idxv[1] = 2;
        tick();
        check("sat.cnt", 32'(b_contador_out), 32'(7));
        check("sat.cleared", 32'(b_sat[2]), 32'(0));
        req[1] = 1'b0;

        // Clear-on-read colliding with a pop on u_b channel 3.
        en[1] = 1'b1; emp[1] = 4'b0111;
        repeat (10) tick();
        req[1] = 1'b1; idxv[1] = 3;
        tick();
        check("col.cnt", 32'(b_contador_out), 32'(5));
        check("col.pop", 32'(b_pop[3]), 32'(1));
        en[1] = 1'b0;
        tick();
        check("col.after", 32'(b_contador_out), 32'(1));
        req[1] = 1'b0;

        // Out-of-range index on the 3-channel u_c.
        en[2] = 1'b1; emp[2] = 4'h0;
        repeat (2) tick();
        en[2] = 1'b0; req[2] = 1'b1; idxv[2] = 3;
        tick();
        check("oor.valid", 32'(c_valid), 32'(1));
        check("oor.err", 32'(c_idx_err), 32'(1));
        check("oor.cnt", 32'(c_contador_out), 32'(0));
        idxv[2] = 0;
        tick();
        check("oor.ch0", 32'(c_contador_out), 32'(2));
        check("oor.err0", 32'(c_idx_err), 32'(0));
        idle_all();

        // Randomised traffic on all three configurations against the model.
        for (int t = 0; t < 3000; t++) begin
            for (int k = 0; k < 3; k++) begin
                en[k]   = ($urandom_range(0, 9) != 0);
                emp[k]  = 4'($urandom) & 4'($urandom);
                req[k]  = ($urandom_range(0, 2) != 0);
                idxv[k] = int'($urandom_range(0, 3));
            end
            tick();
        end
        idle_all();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
